// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory arbiter.
package dmem_pkg;

  localparam int LP_DATA_WIDTH = 32;
  localparam int LP_ADDR_WIDTH = 8;

  // Byte-enable encoding understood by the data memory.
  localparam logic [1:0] LP_BE_BYTE = 2'b00;
  localparam logic [1:0] LP_BE_HALF = 2'b01;
  localparam logic [1:0] LP_BE_WORD = 2'b10;
  localparam logic [1:0] LP_BE_NOP  = 2'b11;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] LP_ST_ARB  = 2'd0;
  localparam logic [1:0] LP_ST_OWN0 = 2'd1;
  localparam logic [1:0] LP_ST_OWN1 = 2'd2;

  // One accepted request as held in the S1 stage.
  typedef struct packed {
    logic                     wen;
    logic [1:0]               be;
    logic [LP_ADDR_WIDTH-1:0] addr;
    logic [LP_DATA_WIDTH-1:0] wdata;
    logic                     owner;
  } dmem_req_t;

  // Owner id to response strobe bit.
  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-side bus of the data-memory arbiter.
// slave = arbiter side, master = requesters plus memory read path.
interface dmem_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 8
);
  logic [1:0]          ireq_valid;
  logic [1:0]          oreq_ready;
  logic [1:0]          ireq_wen;
  logic [1:0]          ireq_lock;
  logic [1:0][1:0]     ireq_be;
  logic [1:0][AW-1:0]  ireq_addr;
  logic [1:0][DW-1:0]  ireq_wdata;
  logic [1:0]          orsp_valid;
  logic [DW-1:0]       orsp_rdata;
  logic [AW-1:0]       omem_addr;
  logic                omem_wen;
  logic [1:0]          omem_be;
  logic [DW-1:0]       omem_wdata;
  logic [DW-1:0]       imem_rdata;

  modport slave (
    input  ireq_valid, ireq_wen, ireq_lock, ireq_be, ireq_addr, ireq_wdata, imem_rdata,
    output oreq_ready, orsp_valid, orsp_rdata, omem_addr, omem_wen, omem_be, omem_wdata
  );

  modport master (
    output ireq_valid, ireq_wen, ireq_lock, ireq_be, ireq_addr, ireq_wdata, imem_rdata,
    input  oreq_ready, orsp_valid, orsp_rdata, omem_addr, omem_wen, omem_be, omem_wdata
  );
endinterface

// File: rtl/dmem_rr_pick.sv
// Combinational two-way round-robin picker: a lone requester wins,
// a contest goes to the requester that was not granted last.
module dmem_rr_pick (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant from current valids and the last winner.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of the single-port data memory.
// Accept at T, memory access from S1 at T+1, response at T+2.
// Optional macro DMEM_ARB_PERF_EN adds saturating accept/stall counters.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MP_DATA_WIDTH = LP_DATA_WIDTH,
  parameter int MP_ADDR_WIDTH = LP_ADDR_WIDTH,
  parameter int MP_MAX_LOCK   = 16,
  parameter int MP_LOCK_CNT_W = 5
) (
  input  logic           iclk,
  input  logic           irst,
  dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]    ocnt_acc0,
  output logic [31:0]    ocnt_acc1,
  output logic [31:0]    ocnt_stall
`endif
);

  logic [1:0]               state_r, state_next;
  logic                     last_grant_r, last_grant_next;
  logic [MP_LOCK_CNT_W-1:0] lock_cnt_r, lock_cnt_next, cnt_inc;
  logic                     own_id;
  logic [1:0]               pick, ready, accept;
  logic                     any_acc, acc_id;
  dmem_req_t                s1_r;
  logic                     s1_valid_r;
  logic [1:0]               rsp_valid_r;
  logic [MP_DATA_WIDTH-1:0] rsp_rdata_r;

  dmem_rr_pick u_pick (
    .valid      (bus.ireq_valid),
    .last_grant (last_grant_r),
    .grant      (pick)
  );

  // Readiness: round-robin in ARB, only the lock holder while owned, none in reset.
  always_comb begin
    ready = 2'b00;
    if (irst) begin
      ready = 2'b00;
    end else begin
      case (state_r)
        LP_ST_ARB:  ready = pick;
        LP_ST_OWN0: ready = {1'b0, bus.ireq_valid[0]};
        LP_ST_OWN1: ready = {bus.ireq_valid[1], 1'b0};
        default:    ready = 2'b00;
      endcase
    end
  end

  assign bus.oreq_ready = ready;
  assign accept         = ready & bus.ireq_valid;
  assign any_acc        = |accept;
  assign acc_id         = accept[1];

  // Lock FSM and pointer update. After a forced release the pointer already
  // names the lock holder, so a contest hands the next grant to the other side.
  always_comb begin
    state_next      = state_r;
    lock_cnt_next   = lock_cnt_r;
    last_grant_next = last_grant_r;
    own_id          = (state_r == LP_ST_OWN1);
    cnt_inc         = lock_cnt_r + {{(MP_LOCK_CNT_W-1){1'b0}}, 1'b1};
    if (any_acc) begin
      last_grant_next = acc_id;
    end else begin
      last_grant_next = last_grant_r;
    end
    case (state_r)
      LP_ST_ARB: begin
        if (any_acc && bus.ireq_lock[acc_id] && (MP_MAX_LOCK > 1)) begin
          state_next    = acc_id ? LP_ST_OWN1 : LP_ST_OWN0;
          lock_cnt_next = {{(MP_LOCK_CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_next    = LP_ST_ARB;
          lock_cnt_next = '0;
        end
      end
      LP_ST_OWN0, LP_ST_OWN1: begin
        if (accept[own_id]) begin
          if (!bus.ireq_lock[own_id] || (cnt_inc >= MP_LOCK_CNT_W'(MP_MAX_LOCK))) begin
            state_next    = LP_ST_ARB;
            lock_cnt_next = '0;
          end else begin
            lock_cnt_next = cnt_inc;
          end
        end else if (!bus.ireq_valid[own_id] && !bus.ireq_lock[own_id]) begin
          state_next    = LP_ST_ARB;
          lock_cnt_next = '0;
        end else begin
          state_next    = state_r;
        end
      end
      default: begin
        state_next    = LP_ST_ARB;
        lock_cnt_next = '0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_r      <= LP_ST_ARB;
      last_grant_r <= 1'b0;
      lock_cnt_r   <= '0;
    end else begin
      state_r      <= state_next;
      last_grant_r <= last_grant_next;
      lock_cnt_r   <= lock_cnt_next;
    end
  end

  // S1 request stage: capture the accepted request with its owner.
  always_ff @(posedge iclk) begin
    if (irst) begin
      s1_valid_r <= 1'b0;
      s1_r       <= '0;
    end else if (any_acc) begin
      s1_valid_r  <= 1'b1;
      s1_r.wen    <= bus.ireq_wen[acc_id];
      s1_r.be     <= bus.ireq_be[acc_id];
      s1_r.addr   <= bus.ireq_addr[acc_id];
      s1_r.wdata  <= bus.ireq_wdata[acc_id];
      s1_r.owner  <= acc_id;
    end else begin
      s1_valid_r <= 1'b0;
    end
  end

  // be=11 and misaligned halves pass through untouched; the memory handles them.
  assign bus.omem_addr  = MP_ADDR_WIDTH'(s1_r.addr);
  assign bus.omem_be    = s1_r.be;
  assign bus.omem_wdata = MP_DATA_WIDTH'(s1_r.wdata);
  assign bus.omem_wen   = s1_valid_r & s1_r.wen & ~irst;

  // Response stage: strobe the owner and return the word read during S1.
  always_ff @(posedge iclk) begin
    if (irst) begin
      rsp_valid_r <= 2'b00;
      rsp_rdata_r <= '0;
    end else begin
      rsp_valid_r <= s1_valid_r ? owner_onehot(s1_r.owner) : 2'b00;
      if (s1_valid_r) begin
        rsp_rdata_r <= bus.imem_rdata;
      end
    end
  end

  assign bus.orsp_valid = rsp_valid_r;
  assign bus.orsp_rdata = rsp_rdata_r;

`ifdef DMEM_ARB_PERF_EN
  logic stall_s;
  assign stall_s = |(bus.ireq_valid & ~ready);

  // Saturating accept and stall counters.
  always_ff @(posedge iclk) begin
    if (irst) begin
      ocnt_acc0  <= 32'd0;
      ocnt_acc1  <= 32'd0;
      ocnt_stall <= 32'd0;
    end else begin
      if (accept[0] && (ocnt_acc0 != 32'hFFFF_FFFF)) ocnt_acc0 <= ocnt_acc0 + 32'd1;
      if (accept[1] && (ocnt_acc1 != 32'hFFFF_FFFF)) ocnt_acc1 <= ocnt_acc1 + 32'd1;
      if (stall_s && (ocnt_stall != 32'hFFFF_FFFF)) ocnt_stall <= ocnt_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural byte-enable memory.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic irst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DW(32), .AW(8)) bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] ocnt_acc0, ocnt_acc1, ocnt_stall;
`endif

  dmem_arbiter dut (
    .iclk (clk),
    .irst (irst),
    .bus  (bus)
`ifdef DMEM_ARB_PERF_EN
    ,
    .ocnt_acc0  (ocnt_acc0),
    .ocnt_acc1  (ocnt_acc1),
    .ocnt_stall (ocnt_stall)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Behavioural memory: 64 words, little-endian lanes, halves wrap in the word.
  logic [31:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_dat = 32'd0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] off,
                                        input logic [1:0] be, input logic [31:0] d);
    logic [31:0] w;
    int n;
    w = old;
    n = (be == 2'b00) ? 1 : (be == 2'b01) ? 2 : (be == 2'b10) ? 4 : 0;
    for (int k = 0; k < n; k++) w[8*((int'(off) + k) % 4) +: 8] = d[8*k +: 8];
    return w;
  endfunction

  assign bus.imem_rdata = mem[bus.omem_addr[7:2]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_dat;
    else if (bus.omem_wen)
      mem[bus.omem_addr[7:2]] <= merge(mem[bus.omem_addr[7:2]], bus.omem_addr[1:0],
                                       bus.omem_be, bus.omem_wdata);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ireq_valid = 2'b00;
    bus.ireq_lock  = 2'b00;
    bus.ireq_wen   = 2'b00;
  endtask

  task automatic drv(input int n, input logic wen, input logic [1:0] be,
                     input logic [7:0] addr, input logic [31:0] wd, input logic lock);
    bus.ireq_valid[n] = 1'b1;
    bus.ireq_wen[n]   = wen;
    bus.ireq_be[n]    = be;
    bus.ireq_addr[n]  = addr;
    bus.ireq_wdata[n] = wd;
    bus.ireq_lock[n]  = lock;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    pre_we  = 1'b1;
    pre_idx = idx;
    pre_dat = val;
    tick();
    pre_we  = 1'b0;
  endtask

  logic [1:0] g2 [0:5] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
  logic [1:0] exp_g;
  int         wcnt;

  initial begin
    irst = 1'b1;
    idle();
    bus.ireq_be    = '0;
    bus.ireq_addr  = '0;
    bus.ireq_wdata = '0;
    tick();
    tick();

    // Reset state, with both requesters asking.
    bus.ireq_valid = 2'b11;
    #1;
    chk("rst_ready", bus.oreq_ready, 2'b00);
    chk("rst_rsp_valid", bus.orsp_valid, 2'b00);
    chk("rst_rsp_rdata", bus.orsp_rdata, 32'd0);
    chk("rst_mem_addr", bus.omem_addr, 8'd0);
    chk("rst_mem_wen", bus.omem_wen, 1'b0);
    chk("rst_mem_be", bus.omem_be, 2'b00);
    chk("rst_mem_wdata", bus.omem_wdata, 32'd0);
    idle();
    preload(6'd4,  32'hDEAD_BEEF);
    preload(6'd5,  32'h1111_2222);
    preload(6'd8,  32'h1122_3344);
    preload(6'd12, 32'h5566_7788);
    irst = 1'b0;

    // 1: single read through the pipeline.
    drv(0, 1'b0, LP_BE_WORD, 8'h10, 32'd0, 1'b0);
    #1;
    chk("t1_ready", bus.oreq_ready, 2'b01);
    tick();
    idle();
    chk("t1_mem_addr", bus.omem_addr, 8'h10);
    chk("t1_mem_wen", bus.omem_wen, 1'b0);
    tick();
    chk("t1_rsp_valid", bus.orsp_valid, 2'b01);
    chk("t1_rsp_rdata", bus.orsp_rdata, 32'hDEAD_BEEF);
    tick();
    chk("t1_rsp_end", bus.orsp_valid, 2'b00);

    // 2: contested reads alternate 1,0,1,0 with responses two cycles later.
    irst = 1'b1;
    tick();
    irst = 1'b0;
    drv(0, 1'b0, LP_BE_WORD, 8'h10, 32'd0, 1'b0);
    drv(1, 1'b0, LP_BE_WORD, 8'h14, 32'd0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k == 4) idle();
      #1;
      chk($sformatf("t2_ready_%0d", k), bus.oreq_ready, g2[k]);
      if (k >= 2) begin
        chk($sformatf("t2_rsp_valid_%0d", k), bus.orsp_valid, g2[k-2]);
        chk($sformatf("t2_rsp_rdata_%0d", k), bus.orsp_rdata,
            (g2[k-2] == 2'b10) ? 32'h1111_2222 : 32'hDEAD_BEEF);
      end else begin
        chk($sformatf("t2_rsp_valid_%0d", k), bus.orsp_valid, 2'b00);
      end
      tick();
    end

    // 3: locked burst of 20 writes by requester 1 against a waiting requester 0.
    irst = 1'b1;
    tick();
    irst = 1'b0;
    wcnt = 0;
    for (int k = 0; k < 23; k++) begin
      if (wcnt < 20) drv(1, 1'b1, LP_BE_WORD, 8'(8'h40 + 4*wcnt), 32'hA000_0000 + 32'(wcnt), 1'b1);
      else begin
        bus.ireq_valid[1] = 1'b0;
        bus.ireq_lock[1]  = 1'b0;
      end
      if (k <= 16) drv(0, 1'b0, LP_BE_WORD, 8'h10, 32'd0, 1'b0);
      else bus.ireq_valid[0] = 1'b0;
      exp_g = (k > 20) ? 2'b00 : (k == 16) ? 2'b01 : 2'b10;
      #1;
      chk($sformatf("t3_ready_%0d", k), bus.oreq_ready, exp_g);
      if (k == 18) begin
        chk("t3_r0_rsp_valid", bus.orsp_valid, 2'b01);
        chk("t3_r0_rsp_rdata", bus.orsp_rdata, 32'hDEAD_BEEF);
      end
      if (exp_g == 2'b10) wcnt++;
      tick();
    end
    idle();
    tick();
    tick();
    chk("t3_mem_first", mem[16], 32'hA000_0000);
    chk("t3_mem_16th", mem[31], 32'hA000_000F);
    chk("t3_mem_last", mem[35], 32'hA000_0013);

    // 4: byte store then read of the same word.
    irst = 1'b1;
    tick();
    irst = 1'b0;
    drv(0, 1'b1, LP_BE_BYTE, 8'h23, 32'h0000_00AB, 1'b0);
    #1;
    chk("t4_ready_w", bus.oreq_ready, 2'b01);
    tick();
    drv(0, 1'b0, LP_BE_WORD, 8'h20, 32'd0, 1'b0);
    chk("t4_mem_addr", bus.omem_addr, 8'h23);
    chk("t4_mem_be", bus.omem_be, LP_BE_BYTE);
    chk("t4_mem_wen", bus.omem_wen, 1'b1);
    #1;
    chk("t4_ready_r", bus.oreq_ready, 2'b01);
    tick();
    idle();
    chk("t4_wr_rsp_valid", bus.orsp_valid, 2'b01);
    chk("t4_wr_rsp_rdata", bus.orsp_rdata, 32'h1122_3344);
    tick();
    chk("t4_rd_rsp_valid", bus.orsp_valid, 2'b01);
    chk("t4_rd_rsp_rdata", bus.orsp_rdata, 32'hAB22_3344);
    chk("t4_mem_word", mem[8], 32'hAB22_3344);

    // 5: reset lands while a write sits in S1.
    drv(0, 1'b1, LP_BE_WORD, 8'h30, 32'hCAFE_F00D, 1'b0);
    #1;
    chk("t5_ready", bus.oreq_ready, 2'b01);
    tick();
    irst = 1'b1;
    bus.ireq_valid = 2'b11;
    #1;
    chk("t5_mem_wen_rst", bus.omem_wen, 1'b0);
    chk("t5_ready_rst", bus.oreq_ready, 2'b00);
    tick();
    irst = 1'b0;
    idle();
    chk("t5_rsp_valid", bus.orsp_valid, 2'b00);
    chk("t5_mem_word", mem[12], 32'h5566_7788);
    chk("t5_mem_wen_after", bus.omem_wen, 1'b0);
    tick();
    chk("t5_rsp_valid_late", bus.orsp_valid, 2'b00);

`ifdef DMEM_ARB_PERF_EN
    // 6: five contested cycles.
    irst = 1'b1;
    tick();
    irst = 1'b0;
    drv(0, 1'b0, LP_BE_WORD, 8'h10, 32'd0, 1'b0);
    drv(1, 1'b0, LP_BE_WORD, 8'h14, 32'd0, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    idle();
    chk("t6_acc_sum", 64'(ocnt_acc0) + 64'(ocnt_acc1), 64'd5);
    chk("t6_stall", ocnt_stall, 32'd5);
    chk("t6_acc0", ocnt_acc0, 32'd2);
    chk("t6_acc1", ocnt_acc1, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
